// File: rtl/edge_catcher_array.sv
// ----------------------------------------------------------------------------
// edge_catcher_array
//
// Multi-channel edge detector for asynchronous level inputs (pins, strobes,
// status lines). Each channel runs a synchroniser chain, a stability filter,
// registered rise/fall pulses, and a sticky pending flag with overrun
// detection. All channels are independent copies of the same logic.
//
// Parameters:
//   WIDTH          number of channels (>=1)
//   SYNC_STAGES    synchroniser flops per channel (>=2)
//   FILTER_CYCLES  consecutive cycles the synchronised level must differ from
//                  q_o before q_o follows (>=1, 1 = no filtering)
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_ni   asynchronous active-low reset
//   d_i      raw asynchronous channel inputs
//   en_i     per-channel pending-flag enable
//   mode_i   per-channel edge select, [2i+1:2i]: 00 none, 01 rise, 10 fall,
//            11 both
//   clr_i    per-channel clear of pend_o/ovf_o
//   q_o      filtered, synchronised level
//   re_o     one-cycle rising-edge pulse
//   fe_o     one-cycle falling-edge pulse
//   pend_o   sticky event-pending flags
//   ovf_o    sticky overrun flags
//   irq_o    OR of all pend_o bits
// ----------------------------------------------------------------------------
module edge_catcher_array #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH-1:0]   d_i,
    input  logic [WIDTH-1:0]   en_i,
    input  logic [2*WIDTH-1:0] mode_i,
    input  logic [WIDTH-1:0]   clr_i,
    output logic [WIDTH-1:0]   q_o,
    output logic [WIDTH-1:0]   re_o,
    output logic [WIDTH-1:0]   fe_o,
    output logic [WIDTH-1:0]   pend_o,
    output logic [WIDTH-1:0]   ovf_o,
    output logic               irq_o
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   level_q;
        logic                   level_d;
        logic                   re_q;
        logic                   re_d;
        logic                   fe_q;
        logic                   fe_d;
        logic                   pend_q;
        logic                   pend_d;
        logic                   ovf_q;
        logic                   ovf_d;
        logic                   sync_lvl;
        logic                   toggle;
        logic                   rise;
        logic                   fall;
        logic                   ev;

        always_comb begin
            sync_d   = {sync_q[SYNC_STAGES-2:0], d_i[gi]};
            sync_lvl = sync_q[SYNC_STAGES-1];

            // The counter only runs while the synchronised level disagrees
            // with q; any agreement restarts it, so short pulses never pass.
            toggle = 1'b0;
            cnt_d  = '0;
            if (sync_lvl != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    toggle = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            level_d = level_q ^ toggle;
            rise    = toggle & ~level_q;
            fall    = toggle & level_q;
            re_d    = rise;
            fe_d    = fall;

            ev = en_i[gi] & ((rise & mode_i[2*gi]) | (fall & mode_i[2*gi+1]));

            // A new event beats a simultaneous clear for pending.
            pend_d = pend_q;
            if (ev) begin
                pend_d = 1'b1;
            end else if (clr_i[gi]) begin
                pend_d = 1'b0;
            end

            // Overrun only when an event lands on an uncleared pending flag;
            // a clear arriving with the event acknowledges the old one.
            ovf_d = ovf_q;
            if (ev && pend_q && !clr_i[gi]) begin
                ovf_d = 1'b1;
            end else if (clr_i[gi]) begin
                ovf_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                re_q    <= 1'b0;
                fe_q    <= 1'b0;
                pend_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                re_q    <= re_d;
                fe_q    <= fe_d;
                pend_q  <= pend_d;
                ovf_q   <= ovf_d;
            end
        end

        assign q_o[gi]    = level_q;
        assign re_o[gi]   = re_q;
        assign fe_o[gi]   = fe_q;
        assign pend_o[gi] = pend_q;
        assign ovf_o[gi]  = ovf_q;
    end

    // pend_o is registered, so the OR cannot glitch on input activity.
    assign irq_o = |pend_o;

endmodule

// File: doc/edge_catcher_array.md
Name: edge_catcher_array

Overview:
Multi-channel, parametrised edge detector for asynchronous level inputs such as pins, strobes and status lines.
- Each channel has a configurable-depth synchroniser, a stability (glitch) filter and registered rise/fall pulses.
- Each channel also has a sticky pending flag with per-channel edge-mode select, an overrun flag and a combined interrupt output.
- Sits between raw external inputs and the interrupt/status logic of the consuming block.

Parameters:
WIDTH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILTER_CYCLES, 1, consecutive cycles a synchronised level must differ from Q before Q follows (>=1; 1 = no filtering)

Ports:
CLK  in  1  clock; all state updates on rising edge
RSTN  in  1  asynchronous active-low reset
D  in  WIDTH  raw asynchronous channel inputs
EN  in  WIDTH  per-channel pending-flag enable
MODE  in  2*WIDTH  per-channel edge select, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
CLR  in  WIDTH  per-channel clear of PEND/OVF, sampled each cycle
Q  out  WIDTH  filtered, synchronised level
RE  out  WIDTH  one-cycle rising-edge pulse
FE  out  WIDTH  one-cycle falling-edge pulse
PEND  out  WIDTH  sticky event-pending flags
OVF  out  WIDTH  sticky overrun flags
IRQ  out  1  OR of all PEND bits

Behaviour:
- Reset: RSTN low asynchronously clears every synchroniser flop, filter counter, Q, RE, FE, PEND and OVF to 0; IRQ therefore reads 0. This applies mid-operation too: a counter in progress is discarded.
- Channels are fully independent; per-channel logic replicated WIDTH times.
- Synchroniser: chain of SYNC_STAGES flops; s[i] = last stage.
- Filter: per-channel counter, width max(1, clog2(FILTER_CYCLES)).
  - If s==Q: counter <= 0.
  - If s!=Q and counter < FILTER_CYCLES-1: counter increments.
  - If s!=Q and counter == FILTER_CYCLES-1: Q toggles and counter <= 0 (the toggle event).
  - Any return of s to Q before the threshold restarts the count; pulses shorter than FILTER_CYCLES sync cycles never reach Q.
- Latency: D stable from before edge k means Q changes at edge k+SYNC_STAGES+FILTER_CYCLES-1. With defaults this is edge k+2.
- Edge pulses (registered): RE=1 for exactly the cycle following a 0->1 toggle event; FE likewise for 1->0. RE and FE are never both 1 on a channel, and they are independent of EN/MODE.
- Event (per channel, on the same edge as the toggle): ev = EN & ((rise & MODE[0]) | (fall & MODE[1])).
- PEND next-state:
  - ev=1 -> 1 (set wins over simultaneous CLR).
  - else CLR=1 -> 0.
  - else hold.
- OVF next-state:
  - ev=1 and PEND=1 and CLR=0 -> 1.
  - else CLR=1 -> 0.
  - else hold.
  - ev with CLR on the same edge: PEND stays 1, OVF cleared.
- Dropping EN blocks new events but does not clear PEND/OVF. Changing MODE takes effect for the next toggle event.
- IRQ is combinational OR of PEND (glitch-free, PEND is registered).
- Post-reset: Q starts at 0. A D held at 1 through reset release therefore produces one RE and a possible PEND after the latency. This is intended.
- No combinational path from D to any output.

Test Plan:
- Defaults, ch0 MODE=01 EN=1, D[0] 0->1 before edge 10 -> Q[0]=1 after edge 12, RE[0]=1 for exactly cycle after edge 12, PEND[0]=1, IRQ=1, FE stays 0.
- FILTER_CYCLES=4, SYNC_STAGES=2: D[1] high for 3 cycles then low -> Q, RE, PEND never change. Then held high 4+ cycles from edge 20 -> Q[1]=1 at edge 25, RE one cycle.
- MODE=10 on ch2, D toggles 0->1->0 with EN=1 -> RE and FE both pulse once; PEND set only on the falling event. Repeat with MODE=00 -> PEND stays 0.
- ch3 PEND=1, second rise without CLR -> OVF[3]=1. Then CLR[3] pulse coincident with a third rise event -> PEND stays 1, OVF cleared. Then a CLR[3] pulse alone -> PEND=0, IRQ=0.
- EN low during an edge -> RE/FE pulse, PEND unchanged. Previously set PEND survives EN falling.
- RSTN asserted between edges while a filter count is in progress with PEND/OVF set -> all outputs 0 immediately (asynchronous). After release with D=1 held -> fresh RE after full latency.
